mu_transition_scheduler: RTL and testbench
==========================================

# mu_transition_scheduler

Synthesizable scheduler for transitions between NORMAL and MEDITATION states. On each accepted request it ramps the per-layer MU (integration-step) values linearly, one step per 4 kHz update strobe, over a programmable number of updates. It sits between the state-select logic and `config_controller`'s MU outputs, replacing the hard switch with a gradual ramp. Its MU outputs drive the cortical column MU inputs directly.

## Interface
- WIDTH, 18, width of the MU outputs (signed).
- MU_NORMAL, 4, MU value in NORMAL for all six layers; legal range 0..7.
- MU_MED_L5B / MU_MED_L5A / MU_MED_L4 / MU_MED_L23, 2 / 2 / 2 / 2, MEDITATION MU per cortical layer; legal range 0..7.
- MIN_RAMP, 8, ramp lengths below this value cause an immediate jump to the target.

- clk  in  1  system clock, 125 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  one-cycle update strobe (4 kHz).
- req_valid  in  1  transition request.
- req_state  in  3  target state: 0 = NORMAL, 1 = MEDITATION; all other codes are invalid.
- ramp_len  in  20  ramp duration, counted in clk_en updates.
- req_ready  out  1  high only in IDLE.
- req_err  out  1  one-cycle pulse when an invalid req_state is presented while req_ready is high.
- mu_dt_theta, mu_dt_l6  out  WIDTH  held at MU_NORMAL.
- mu_dt_l5b, mu_dt_l5a, mu_dt_l4, mu_dt_l23  out  WIDTH  ramped MU outputs.
- active_state  out  3  last completed target state.
- ramping  out  1  high while in RAMP.
- done  out  1  one-cycle completion pulse.
- ramp_count  out  20  number of updates elapsed in the current ramp.

## Operation
- Reset values:
  - All MU outputs = MU_NORMAL.
  - active_state = 0; state = IDLE; req_ready = 1.
  - req_err, done, ramping, ramp_count and all accumulators = 0.
- FSM states: IDLE, RAMP, DONE.
- IDLE, on req_valid && req_ready:
  - Invalid code: pulse req_err; stay in IDLE; the request is dropped.
  - req_state == active_state: go to DONE with no MU change.
  - Otherwise:
    - Latch N = ramp_len.
    - Latch start values from the current outputs, and per-layer target values from the target table.
    - Per layer: mag = |target − start|, sign = sign(target − start).
    - Clear the accumulators and ramp_count.
    - If N < MIN_RAMP: load the targets directly and go to DONE.
    - Otherwise go to RAMP.
- RAMP, on each clk_en:
  - ramp_count += 1.
  - Per layer: acc += mag. If acc ≥ N, then output += sign and acc −= N. At most one step per layer per update; this is guaranteed because mag ≤ 7 < MIN_RAMP ≤ N.
  - When ramp_count reaches N, force every output to its target (a safety load; it equals the stepped value) and go to DONE.
- Resulting output after k updates: start + sign·floor(k·mag/N). This equals truncation toward zero of diff·k/N.
- DONE: done = 1 for one cycle; active_state ← target; ramping = 0; return to IDLE.
- Requests are not accepted in RAMP or DONE. A held req_valid is accepted on the first IDLE cycle.
- clk_en outside RAMP is ignored.
- mu_dt_theta and mu_dt_l6 never change.
- Reset asserted mid-ramp: all outputs return to reset values asynchronously. No done pulse is produced.

## Timing
- All outputs are registered.
- Acceptance edge T: ramping = 1 and req_ready = 0 from T+1.
- An output step becomes visible one cycle after the clk_en cycle that causes it.
- The N-th clk_en sampled at edge E: outputs = targets at E+1 and done = 1 during the E+1 cycle; req_ready = 1 from E+2.
- Immediate jump (N < MIN_RAMP, or same target state): targets visible at T+1, done high during T+1, req_ready high from T+2.
- clk_en coincident with the acceptance edge is not counted.

## Test plan
- Reset release, no request, 100 clk_en strobes → all MU = 4; active_state = 0; req_ready = 1; done never pulses.
- NORMAL→MED, ramp_len = 8, default parameters → mu_dt_l5b = 4 after updates 1–3, 3 after updates 4–7, 2 after update 8; done pulses 1 cycle after the 8th strobe; active_state = 1; theta/L6 stay at 4.
- MED→NORMAL, ramp_len = 80000 → mu_dt_l23 reaches 3 at update 40000 and 4 at update 80000; ramp_count = 80000 at done; a request issued mid-ramp is held until req_ready returns.
- req_state = 5 in IDLE → req_err pulses for 1 cycle; outputs unchanged. ramp_len = 3 to MEDITATION → layers = 2 one cycle after acceptance, with done in that same cycle.
- Per-layer targets MU_MED_L4 = 1, MU_MED_L5B = 3, ramp_len = 12 → at update 4: l4 = 3, l5b = 4; at update 12: l4 = 1, l5b = 3.
- rst_n asserted at update 5 of a 20-update ramp → all MU = 4 immediately; active_state = 0; no done; a fresh request is accepted normally after release.

Source files
------------

// File: rtl/mu_transition_scheduler.sv
// mu_transition_scheduler
// Ramps the per-layer MU (integration-step) outputs linearly between the NORMAL
// and MEDITATION tables, one step per update strobe, over a programmable number
// of updates. Each layer uses a Bresenham-style accumulator, so after k updates
// the output is start + sign * floor(k * mag / N) with no divider.
//
// Ports
//   clk, rst_n         : system clock, asynchronous active-low reset
//   clk_en             : one-cycle update strobe; counted only in RAMP
//   req_valid/ready    : transition handshake; ready is high only in IDLE
//   req_state          : 0 = NORMAL, 1 = MEDITATION, other codes rejected
//   ramp_len           : ramp length in updates; < MIN_RAMP jumps immediately
//   req_err            : one-cycle pulse for a rejected request code
//   mu_dt_*            : MU outputs (theta and L6 are constant)
//   active_state       : last completed target state
//   ramping, done      : RAMP indicator, one-cycle completion pulse
//   ramp_count         : updates elapsed in the current ramp
module mu_transition_scheduler #(
  parameter int WIDTH      = 18,
  parameter int MU_NORMAL  = 4,
  parameter int MU_MED_L5B = 2,
  parameter int MU_MED_L5A = 2,
  parameter int MU_MED_L4  = 2,
  parameter int MU_MED_L23 = 2,
  parameter int MIN_RAMP   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    req_valid,
  input  logic [2:0]              req_state,
  input  logic [19:0]             ramp_len,
  output logic                    req_ready,
  output logic                    req_err,
  output logic signed [WIDTH-1:0] mu_dt_theta,
  output logic signed [WIDTH-1:0] mu_dt_l6,
  output logic signed [WIDTH-1:0] mu_dt_l5b,
  output logic signed [WIDTH-1:0] mu_dt_l5a,
  output logic signed [WIDTH-1:0] mu_dt_l4,
  output logic signed [WIDTH-1:0] mu_dt_l23,
  output logic [2:0]              active_state,
  output logic                    ramping,
  output logic                    done,
  output logic [19:0]             ramp_count
);

  localparam logic signed [WIDTH-1:0] MuNorm = WIDTH'(MU_NORMAL);
  localparam logic signed [WIDTH-1:0] MuL5b  = WIDTH'(MU_MED_L5B);
  localparam logic signed [WIDTH-1:0] MuL5a  = WIDTH'(MU_MED_L5A);
  localparam logic signed [WIDTH-1:0] MuL4   = WIDTH'(MU_MED_L4);
  localparam logic signed [WIDTH-1:0] MuL23  = WIDTH'(MU_MED_L23);
  localparam logic signed [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [19:0]             MinRamp = 20'(MIN_RAMP);

  typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

  state_e                  state_q, state_d;
  logic [19:0]             n_q, n_d;
  logic [19:0]             cnt_q, cnt_d;
  logic [2:0]              act_q, act_d;
  logic [2:0]              tst_q, tst_d;
  logic                    err_q, err_d;
  // Layer index: 0 = L5B, 1 = L5A, 2 = L4, 3 = L23.
  logic signed [WIDTH-1:0] mu_q [4];
  logic signed [WIDTH-1:0] mu_d [4];
  logic signed [WIDTH-1:0] tgt_q [4];
  logic signed [WIDTH-1:0] tgt_d [4];
  logic [19:0]             acc_q [4];
  logic [19:0]             acc_d [4];
  logic [2:0]              mag_q [4];
  logic [2:0]              mag_d [4];
  logic                    dn_q [4];
  logic                    dn_d [4];

  logic signed [WIDTH-1:0] new_tgt [4];
  logic signed [WIDTH-1:0] new_diff [4];
  logic [2:0]              new_mag [4];
  logic [20:0]             sum [4];

  function automatic logic signed [WIDTH-1:0] tgt_of(input logic med, input int layer);
    if (!med) return MuNorm;
    case (layer)
      0:       return MuL5b;
      1:       return MuL5a;
      2:       return MuL4;
      default: return MuL23;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      new_tgt[i]  = tgt_of(req_state[0], i);
      new_diff[i] = new_tgt[i] - mu_q[i];
      new_mag[i]  = new_diff[i][WIDTH-1] ? 3'(-new_diff[i]) : 3'(new_diff[i]);
      // One bit of headroom: acc < N, so acc + mag never wraps.
      sum[i]      = {1'b0, acc_q[i]} + {18'd0, mag_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    tst_d   = tst_q;
    err_d   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mu_d[i]  = mu_q[i];
      tgt_d[i] = tgt_q[i];
      acc_d[i] = acc_q[i];
      mag_d[i] = mag_q[i];
      dn_d[i]  = dn_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_state > 3'd1) begin
            err_d = 1'b1;
          end else if (req_state == act_q) begin
            tst_d   = req_state;
            state_d = StDone;
          end else begin
            tst_d = req_state;
            n_d   = ramp_len;
            cnt_d = '0;
            for (int i = 0; i < 4; i++) begin
              tgt_d[i] = new_tgt[i];
              acc_d[i] = '0;
              mag_d[i] = new_mag[i];
              dn_d[i]  = new_diff[i][WIDTH-1];
            end
            if (ramp_len < MinRamp) begin
              for (int i = 0; i < 4; i++) mu_d[i] = new_tgt[i];
              state_d = StDone;
            end else begin
              state_d = StRamp;
            end
          end
        end
      end
      StRamp: begin
        if (clk_en) begin
          cnt_d = cnt_q + 20'd1;
          for (int i = 0; i < 4; i++) begin
            if (sum[i] >= {1'b0, n_q}) begin
              mu_d[i]  = dn_q[i] ? mu_q[i] - One : mu_q[i] + One;
              acc_d[i] = 20'(sum[i] - {1'b0, n_q});
            end else begin
              acc_d[i] = sum[i][19:0];
            end
          end
          // Final load equals the stepped value; it guards against drift.
          if (cnt_q + 20'd1 == n_q) begin
            for (int i = 0; i < 4; i++) mu_d[i] = tgt_q[i];
            state_d = StDone;
          end
        end
      end
      StDone: begin
        act_d   = tst_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      tst_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mu_q[i]  <= MuNorm;
        tgt_q[i] <= MuNorm;
        acc_q[i] <= '0;
        mag_q[i] <= '0;
        dn_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      tst_q   <= tst_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) begin
        mu_q[i]  <= mu_d[i];
        tgt_q[i] <= tgt_d[i];
        acc_q[i] <= acc_d[i];
        mag_q[i] <= mag_d[i];
        dn_q[i]  <= dn_d[i];
      end
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign ramping      = (state_q == StRamp);
  assign done         = (state_q == StDone);
  assign req_err      = err_q;
  assign active_state = act_q;
  assign ramp_count   = cnt_q;
  assign mu_dt_theta  = MuNorm;
  assign mu_dt_l6     = MuNorm;
  assign mu_dt_l5b    = mu_q[0];
  assign mu_dt_l5a    = mu_q[1];
  assign mu_dt_l4     = mu_q[2];
  assign mu_dt_l23    = mu_q[3];

endmodule

// File: tb/tb_mu_transition_scheduler.sv
// Self-checking bench for mu_transition_scheduler. Two instances share all
// inputs: one with default tables, one with MU_MED_L5B = 3 and MU_MED_L4 = 1.
// Expected MU values come from start + trunc((target - start) * k / N).
module tb_mu_transition_scheduler;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_state = '0;
  logic [19:0] ramp_len = '0;

  logic          ready_a, err_a, ramping_a, done_a;
  logic [2:0]    act_a;
  logic [19:0]   cnt_a;
  logic signed [W-1:0] theta_a, l6_a;
  logic signed [W-1:0] mu_a [4];

  logic          ready_b, err_b, ramping_b, done_b;
  logic [2:0]    act_b;
  logic [19:0]   cnt_b;
  logic signed [W-1:0] theta_b, l6_b;
  logic signed [W-1:0] mu_b [4];

  int passes = 0;
  int fails = 0;
  int total = 0;

  // Reference model state (layer order: L5B, L5A, L4, L23).
  int cur_a [4];
  int cur_b [4];
  int s_a [4];
  int s_b [4];
  int t_a [4];
  int t_b [4];
  int exp_a [4];
  int exp_b [4];
  int act = 0;

  always #4 clk = ~clk;

  mu_transition_scheduler u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .req_valid    (req_valid),
    .req_state    (req_state),
    .ramp_len     (ramp_len),
    .req_ready    (ready_a),
    .req_err      (err_a),
    .mu_dt_theta  (theta_a),
    .mu_dt_l6     (l6_a),
    .mu_dt_l5b    (mu_a[0]),
    .mu_dt_l5a    (mu_a[1]),
    .mu_dt_l4     (mu_a[2]),
    .mu_dt_l23    (mu_a[3]),
    .active_state (act_a),
    .ramping      (ramping_a),
    .done         (done_a),
    .ramp_count   (cnt_a)
  );

  mu_transition_scheduler #(
    .MU_MED_L5B (3),
    .MU_MED_L4  (1)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .req_valid    (req_valid),
    .req_state    (req_state),
    .ramp_len     (ramp_len),
    .req_ready    (ready_b),
    .req_err      (err_b),
    .mu_dt_theta  (theta_b),
    .mu_dt_l6     (l6_b),
    .mu_dt_l5b    (mu_b[0]),
    .mu_dt_l5a    (mu_b[1]),
    .mu_dt_l4     (mu_b[2]),
    .mu_dt_l23    (mu_b[3]),
    .active_state (act_b),
    .ramping      (ramping_b),
    .done         (done_b),
    .ramp_count   (cnt_b)
  );

  function automatic int tgt(input bit inst_b, input int st, input int layer);
    if (st == 0) return 4;
    if (inst_b && layer == 0) return 3;
    if (inst_b && layer == 2) return 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mu(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_a_layer%0d", tag, i), mu_a[i], exp_a[i]);
      chk($sformatf("%s_b_layer%0d", tag, i), mu_b[i], exp_b[i]);
    end
    chk({tag, "_theta"}, theta_a, 4);
    chk({tag, "_l6"}, l6_b, 4);
  endtask

  task automatic exp_from_cur();
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = cur_a[i];
      exp_b[i] = cur_b[i];
    end
  endtask

  task automatic exp_ramp(input int k, input int n);
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = s_a[i] + ((t_a[i] - s_a[i]) * k) / n;
      exp_b[i] = s_b[i] + ((t_b[i] - s_b[i]) * k) / n;
    end
  endtask

  // One request; hold_k re-raises req_valid (MEDITATION, length 3) at that
  // update and leaves it held; abort_k asserts reset right after that update.
  task automatic run_req(input int st, input int n, input bit en_acc,
                         input int hold_k, input int abort_k);
    int waited = 0;
    while (!ready_a && waited < 200) begin
      step();
      waited++;
    end
    chk("ready_before_req", ready_a, 1);
    for (int i = 0; i < 4; i++) begin
      s_a[i] = cur_a[i];
      s_b[i] = cur_b[i];
      t_a[i] = tgt(1'b0, st, i);
      t_b[i] = tgt(1'b1, st, i);
    end
    req_valid = 1'b1;
    req_state = 3'(st);
    ramp_len  = 20'(n);
    clk_en    = en_acc;
    step();
    req_valid = 1'b0;
    clk_en    = 1'b0;

    if (st > 1) begin
      chk("err_pulse", err_a, 1);
      chk("err_ready", ready_b, 1);
      exp_from_cur();
      check_mu("err_unchanged");
      step();
      chk("err_one_cycle", err_b, 0);
      chk("err_active", act_a, act);
      return;
    end
    chk("no_err", err_a, 0);

    if (st == act || n < 8) begin
      chk("jump_done", done_a, 1);
      chk("jump_not_ramping", ramping_b, 0);
      for (int i = 0; i < 4; i++) begin
        cur_a[i] = t_a[i];
        cur_b[i] = t_b[i];
      end
      exp_from_cur();
      check_mu("jump");
      step();
      chk("jump_done_cleared", done_b, 0);
      chk("jump_ready", ready_a, 1);
      act = st;
      chk("jump_active", act_a, act);
      return;
    end

    chk("ramp_start", ramping_a, 1);
    chk("ramp_start_busy", ready_a, 0);
    chk("ramp_start_count", cnt_a, 0);
    for (int k = 1; k <= n; k++) begin
      if (n <= 64) repeat ($urandom_range(0, 2)) step();
      if (hold_k == k) begin
        req_valid = 1'b1;
        req_state = 3'd1;
        ramp_len  = 20'd3;
      end
      clk_en = 1'b1;
      step();
      clk_en = 1'b0;
      if (abort_k == k) begin
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
          cur_a[i] = 4;
          cur_b[i] = 4;
        end
        act = 0;
        exp_from_cur();
        check_mu("abort");
        chk("abort_active", act_a, 0);
        chk("abort_ready", ready_b, 1);
        chk("abort_ramping", ramping_a, 0);
        chk("abort_count", cnt_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("abort_no_done", done_a | done_b, 0);
        step();
        chk("abort_no_done2", done_a | done_b, 0);
        return;
      end
      if (n <= 64 || k == n / 2 - 1 || k == n / 2 || k == n) begin
        exp_ramp(k, n);
        check_mu($sformatf("ramp_n%0d_k%0d", n, k));
        chk($sformatf("count_k%0d", k), cnt_a, k);
        chk($sformatf("done_k%0d", k), done_a, (k == n) ? 1 : 0);
        chk($sformatf("busy_k%0d", k), ready_b, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cur_a[i] = t_a[i];
      cur_b[i] = t_b[i];
    end
    step();
    chk("ramp_done_cleared", done_a, 0);
    chk("ramp_ready", ready_a, 1);
    act = st;
    chk("ramp_active", act_b, act);
  endtask

  initial begin
    int done_seen;
    int st;
    int n;
    for (int i = 0; i < 4; i++) begin
      cur_a[i] = 4;
      cur_b[i] = 4;
    end

    repeat (3) step();
    exp_from_cur();
    check_mu("reset");
    chk("reset_ready", ready_a, 1);
    chk("reset_err", err_a, 0);
    chk("reset_done", done_b, 0);
    chk("reset_ramping", ramping_a, 0);
    chk("reset_count", cnt_a, 0);
    chk("reset_active", act_a, 0);
    rst_n = 1'b1;
    step();

    done_seen = 0;
    repeat (100) begin
      clk_en = 1'b1;
      step();
      clk_en = 1'b0;
      if (done_a || done_b) done_seen++;
      step();
    end
    chk("idle_no_done", done_seen, 0);
    exp_from_cur();
    check_mu("idle");
    chk("idle_active", act_a, 0);
    chk("idle_ready", ready_a, 1);

    run_req(1, 8, 1'b0, 0, 0);        // NORMAL -> MEDITATION, 8 updates
    run_req(0, 60000, 1'b0, 30000, 0); // long ramp back, request held mid-ramp
    run_req(1, 3, 1'b0, 0, 0);        // the held request: immediate jump
    run_req(5, 10, 1'b0, 0, 0);       // invalid code
    run_req(1, 20, 1'b0, 0, 0);       // already in MEDITATION
    run_req(0, 12, 1'b1, 0, 0);       // strobe on the acceptance edge
    run_req(1, 12, 1'b0, 0, 0);       // per-layer targets on instance b
    run_req(0, 20, 1'b0, 0, 5);       // reset at update 5
    run_req(1, 8, 1'b0, 0, 0);        // fresh request after reset

    repeat (12) begin
      if ($urandom_range(0, 9) == 0) st = int'($urandom_range(2, 7));
      else st = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) n = int'($urandom_range(0, 7));
      else n = int'($urandom_range(8, 40));
      run_req(st, n, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
